// File: rtl/axis_block_mean_subtractor.sv
// axis_block_mean_subtractor
//
// Collects one block of N = 2**BLOCK_SIZE_LOG AXIS samples, works out the
// block mean (sum >>> BLOCK_SIZE_LOG, rounding toward -inf) and replays the
// stored block as (sample - mean). The last replayed sample of each block is
// flagged with output_last. The centred residual stream feeds the
// clamper/partial-sum stages.
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst           asynchronous, active-high reset
//   input_valid   AXIS input valid
//   input_ready   AXIS input ready (registered, high only while filling)
//   input_data    input sample, DATA_WIDTH bits
//   output_valid  AXIS output valid
//   output_ready  AXIS output ready
//   output_data   signed (sample - mean), DATA_WIDTH+1 bits
//   output_last   high with the N-th output sample of each block
module axis_block_mean_subtractor #(
    parameter int DATA_WIDTH     = 16,
    parameter int BLOCK_SIZE_LOG = 8,
    parameter bit IS_SIGNED      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [DATA_WIDTH:0]   output_data,
    output logic                  output_last
);

    localparam int N      = 1 << BLOCK_SIZE_LOG;
    localparam int ADDR_W = (BLOCK_SIZE_LOG > 0) ? BLOCK_SIZE_LOG : 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int ACC_W  = DATA_WIDTH + BLOCK_SIZE_LOG;
    localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [BLOCK_SIZE_LOG:0] RD_END    = (BLOCK_SIZE_LOG + 1)'(N);
    localparam logic [BLOCK_SIZE_LOG:0] RD_LAST   = (BLOCK_SIZE_LOG + 1)'(N - 1);

    typedef enum logic [1:0] {
        FILL,
        MEAN,
        DRAIN
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    ready_q;
    logic [ADDR_W-1:0]       wr_ptr;
    logic [BLOCK_SIZE_LOG:0] rd_ptr;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_add;
    logic [DATA_WIDTH-1:0]   mean_q;
    logic [DATA_WIDTH-1:0]   mean_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    rd_issue;
    logic                    rd_is_last;
    logic                    rd_pend;
    logic                    rd_last_pend;

    logic [DATA_WIDTH:0]     sample_ext;
    logic [DATA_WIDTH:0]     mean_ext;
    logic [DATA_WIDTH:0]     diff;

    logic [1:0]              count;
    logic [DATA_WIDTH:0]     ent0_data;
    logic [DATA_WIDTH:0]     ent1_data;
    logic                    ent0_last;
    logic                    ent1_last;

    logic                    in_hs;
    logic                    out_hs;

    // input_ready is a register so it stays low for the whole of reset and
    // rises on the first clock after release.
    assign input_ready  = ready_q;
    assign output_valid = (count != 2'd0);
    assign output_data  = ent0_data;
    assign output_last  = output_valid && ent0_last;
    assign in_hs        = input_valid && ready_q;
    assign out_hs       = output_valid && output_ready;

    // Sign- or zero-extension of the incoming sample, the mean and the
    // replayed sample, plus the residual itself.
    always_comb begin
        if (IS_SIGNED) begin
            acc_add    = ACC_W'($signed(input_data));
            mean_d     = DATA_WIDTH'($signed(acc) >>> BLOCK_SIZE_LOG);
            sample_ext = (DATA_WIDTH + 1)'($signed(rd_data));
            mean_ext   = (DATA_WIDTH + 1)'($signed(mean_q));
        end else begin
            acc_add    = ACC_W'(input_data);
            mean_d     = DATA_WIDTH'(acc >> BLOCK_SIZE_LOG);
            sample_ext = {1'b0, rd_data};
            mean_ext   = {1'b0, mean_q};
        end
        diff = sample_ext - mean_ext;
    end

    // Next-state and read-issue logic. During DRAIN a read is only issued if
    // the result is guaranteed a slot in the 2-entry output stage when it
    // lands, counting the read already in flight and any pop this cycle.
    // That keeps one output per cycle under continuous output_ready.
    always_comb begin
        state_d    = state_q;
        rd_issue   = 1'b0;
        rd_addr    = '0;
        rd_is_last = 1'b0;
        case (state_q)
            FILL: begin
                if (in_hs && (wr_ptr == LAST_ADDR)) begin
                    state_d = MEAN;
                end
            end
            MEAN: begin
                rd_issue   = 1'b1;
                rd_is_last = (N == 1);
                state_d    = DRAIN;
            end
            DRAIN: begin
                if ((rd_ptr != RD_END) &&
                    (({1'b0, count} + {2'b00, rd_pend}) <= (3'd1 + {2'b00, out_hs}))) begin
                    rd_issue   = 1'b1;
                    rd_addr    = rd_ptr[ADDR_W-1:0];
                    rd_is_last = (rd_ptr == RD_LAST);
                end
                if (out_hs && output_last) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Control registers: state, pointers, accumulator and mean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            ready_q      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            acc          <= '0;
            mean_q       <= '0;
            rd_pend      <= 1'b0;
            rd_last_pend <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= (state_d == FILL);
            rd_pend      <= rd_issue;
            rd_last_pend <= rd_is_last;
            if (in_hs) begin
                wr_ptr <= wr_ptr + 1'b1;
                acc    <= acc + acc_add;
            end
            if (state_q == MEAN) begin
                mean_q <= mean_d;
                rd_ptr <= (BLOCK_SIZE_LOG + 1)'(1);
            end else if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (out_hs && output_last) begin
                acc    <= '0;
                wr_ptr <= '0;
            end
        end
    end

    // Block buffer with a synchronous read port.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            mem[wr_ptr] <= input_data;
        end
        if (rd_issue) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Two-entry output stage; entry 0 is the head presented on the port, so
    // data and last hold still while output_ready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= 2'd0;
            ent0_data <= '0;
            ent1_data <= '0;
            ent0_last <= 1'b0;
            ent1_last <= 1'b0;
        end else begin
            case ({rd_pend, out_hs})
                2'b10: begin
                    if (count == 2'd0) begin
                        ent0_data <= diff;
                        ent0_last <= rd_last_pend;
                    end else begin
                        ent1_data <= diff;
                        ent1_last <= rd_last_pend;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0_data <= ent1_data;
                    ent0_last <= ent1_last;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0_data <= diff;
                        ent0_last <= rd_last_pend;
                    end else begin
                        ent0_data <= ent1_data;
                        ent0_last <= ent1_last;
                        ent1_data <= diff;
                        ent1_last <= rd_last_pend;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_block_mean_subtractor.sv
// tb_axis_block_mean_subtractor
//
// Bench for axis_block_mean_subtractor. A default unsigned instance
// (16-bit, 256-sample blocks) is driven with ramp, constant, back-to-back,
// backpressured and reset-interrupted blocks, with expected residuals queued
// when each block is accepted. A small signed instance and an N=1 instance
// are checked from short tables.
module tb_axis_block_mean_subtractor;

    localparam int DW  = 16;
    localparam int BSL = 8;
    localparam int N   = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // Default instance
    logic          input_valid;
    logic          input_ready;
    logic [DW-1:0] input_data;
    logic          output_valid;
    logic          output_ready = 1'b1;
    logic [DW:0]   output_data;
    logic          output_last;

    // Signed instance: 6-bit samples, 4-sample blocks
    logic          s_input_valid;
    logic          s_input_ready;
    logic [5:0]    s_input_data;
    logic          s_output_valid;
    logic          s_output_ready;
    logic [6:0]    s_output_data;
    logic          s_output_last;

    // N=1 instance: 8-bit unsigned samples
    logic          u_input_valid;
    logic          u_input_ready;
    logic [7:0]    u_input_data;
    logic          u_output_valid;
    logic          u_output_ready;
    logic [8:0]    u_output_data;
    logic          u_output_last;

    axis_block_mean_subtractor #(.DATA_WIDTH(DW), .BLOCK_SIZE_LOG(BSL), .IS_SIGNED(1'b0)) dut (
        .clk(clk), .rst(rst),
        .input_valid(input_valid), .input_ready(input_ready), .input_data(input_data),
        .output_valid(output_valid), .output_ready(output_ready),
        .output_data(output_data), .output_last(output_last)
    );

    axis_block_mean_subtractor #(.DATA_WIDTH(6), .BLOCK_SIZE_LOG(2), .IS_SIGNED(1'b1)) dut_signed (
        .clk(clk), .rst(rst),
        .input_valid(s_input_valid), .input_ready(s_input_ready), .input_data(s_input_data),
        .output_valid(s_output_valid), .output_ready(s_output_ready),
        .output_data(s_output_data), .output_last(s_output_last)
    );

    axis_block_mean_subtractor #(.DATA_WIDTH(8), .BLOCK_SIZE_LOG(0), .IS_SIGNED(1'b0)) dut_n1 (
        .clk(clk), .rst(rst),
        .input_valid(u_input_valid), .input_ready(u_input_ready), .input_data(u_input_data),
        .output_valid(u_output_valid), .output_ready(u_output_ready),
        .output_data(u_output_data), .output_last(u_output_last)
    );

    typedef struct {
        logic signed [DW:0] data;
        logic               last;
    } exp_t;

    typedef struct {
        logic [5:0]        din;
        logic signed [6:0] dout;
        logic              last;
    } svec_t;

    typedef struct {
        logic [7:0] din;
        logic [8:0] dout;
        logic       last;
    } uvec_t;

    exp_t exp_q[$];
    int   errors     = 0;
    int   checks     = 0;
    int   out_seen   = 0;
    bit   rand_ready = 1'b0;

    bit          stall_pending      = 1'b0;
    bit          ready_rise_pending = 1'b0;
    logic [DW:0] held_data;
    logic        held_last;

    // One comparison: counts it and reports it when it does not hold.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Output monitor: picks output_ready for the coming edge, then checks
    // whatever the DUT presents against the head of the expected queue and
    // checks held outputs stayed put across a stall.
    always @(negedge clk) begin
        exp_t e;
        output_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rst) begin
            stall_pending      = 1'b0;
            ready_rise_pending = 1'b0;
        end else begin
            if (ready_rise_pending) begin
                checkOutput("ready_after_last", input_ready, 1);
                ready_rise_pending = 1'b0;
            end
            if (stall_pending) begin
                checkOutput("stall_hold",
                            ({output_valid, output_last, output_data} == {1'b1, held_last, held_data}), 1);
                stall_pending = 1'b0;
            end
            if (output_valid && output_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_output", output_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("out_data", $signed(output_data), e.data);
                    checkOutput("out_last", output_last, e.last);
                    if (output_last) begin
                        checkOutput("ready_at_last", input_ready, 0);
                        ready_rise_pending = 1'b1;
                    end
                end
                out_seen++;
            end else if (output_valid) begin
                held_data     = output_data;
                held_last     = output_last;
                stall_pending = 1'b1;
            end
        end
    end

    // Feeds count samples (ramp from base, or constant base) into the default
    // instance, optionally gated 10 cycles on / 10 off. A full block queues
    // its expected residuals using the floor of the block average. With
    // timing set, the cycles after the last handshake are checked while junk
    // is presented on the input.
    task automatic applyStimulus(input int base, input int count, input bit ramp,
                                 input bit gate, input bit timing);
        int            idx = 0;
        int            cyc = 0;
        longint        sum = 0;
        longint        mean;
        logic [DW-1:0] samples[$];
        exp_t          e;
        while (idx < count && cyc < 20000) begin
            @(negedge clk);
            if (!gate || ((cyc / 10) % 2 == 0)) begin
                input_valid = 1'b1;
                input_data  = ramp ? DW'(base + idx) : DW'(base);
            end else begin
                input_valid = 1'b0;
            end
            if (input_valid && input_ready) begin
                samples.push_back(input_data);
                sum += longint'(input_data);
                idx++;
            end
            cyc++;
        end
        if (idx != count) begin
            checkOutput("input_timeout", idx, count);
        end
        if (count == N && idx == N) begin
            mean = sum / N;
            for (int i = 0; i < N; i++) begin
                e.data = (DW + 1)'(longint'(samples[i]) - mean);
                e.last = (i == N - 1);
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
        if (timing) begin
            input_valid = 1'b1;
            input_data  = 16'hBEEF;
            checkOutput("ready_low_after_block", input_ready, 0);
            checkOutput("valid_lat_c1", output_valid, 0);
            @(negedge clk);
            checkOutput("valid_lat_c2", output_valid, 0);
            @(negedge clk);
            checkOutput("valid_lat_c3", output_valid, 1);
        end
        input_valid = 1'b0;
    endtask

    // Waits until every queued expected output has been seen.
    task automatic waitDrain();
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", exp_q.size(), 0);
        end
        @(negedge clk);
    endtask

    // Pulses the shared reset mid-cycle and checks the asynchronous effect.
    task automatic doReset();
        @(negedge clk);
        #1;
        rst           = 1'b1;
        input_valid   = 1'b0;
        s_input_valid = 1'b0;
        u_input_valid = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("rst_valid", output_valid, 0);
        checkOutput("rst_last", output_last, 0);
        checkOutput("rst_data", output_data, 0);
        checkOutput("rst_ready", input_ready, 0);
        checkOutput("rst_s_valid", s_output_valid, 0);
        checkOutput("rst_u_ready", u_input_ready, 0);
        @(negedge clk);
        checkOutput("rst_ready_held", input_ready, 0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", input_ready, 1);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        svec_t stab[4];
        uvec_t utab[3];
        int    idx;
        int    cyc;
        int    start;

        stab[0] = '{din: 6'b100000, dout: -7'sd31, last: 1'b0};
        stab[1] = '{din: 6'b011111, dout:  7'sd32, last: 1'b0};
        stab[2] = '{din: 6'b111111, dout:  7'sd0,  last: 1'b0};
        stab[3] = '{din: 6'b000000, dout:  7'sd1,  last: 1'b1};
        utab[0] = '{din: 8'h00, dout: 9'd0, last: 1'b1};
        utab[1] = '{din: 8'hFF, dout: 9'd0, last: 1'b1};
        utab[2] = '{din: 8'h5A, dout: 9'd0, last: 1'b1};

        input_valid    = 1'b0;
        input_data     = '0;
        s_input_valid  = 1'b0;
        s_input_data   = '0;
        s_output_ready = 1'b1;
        u_input_valid  = 1'b0;
        u_input_data   = '0;
        u_output_ready = 1'b1;

        doReset();

        // Signed block {-32, 31, -1, 0}: mean -1
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 100) begin
            @(negedge clk);
            s_input_valid = 1'b1;
            s_input_data  = stab[idx].din;
            if (s_input_ready) idx++;
            cyc++;
        end
        @(negedge clk);
        s_input_valid = 1'b0;
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (s_output_valid) begin
                checkOutput("signed_data", $signed(s_output_data), stab[idx].dout);
                checkOutput("signed_last", s_output_last, stab[idx].last);
                idx++;
            end
        end
        if (idx != 4) checkOutput("signed_timeout", idx, 4);

        // N=1: every output is 0 and flagged last
        for (int i = 0; i < 3; i++) begin
            idx = 0;
            cyc = 0;
            while (idx < 1 && cyc < 50) begin
                @(negedge clk);
                u_input_valid = 1'b1;
                u_input_data  = utab[i].din;
                if (u_input_ready) idx++;
                cyc++;
            end
            @(negedge clk);
            u_input_valid = 1'b0;
            checkOutput("n1_ready_low", u_input_ready, 0);
            idx = 0;
            cyc = 0;
            while (idx < 1 && cyc < 50) begin
                @(negedge clk);
                cyc++;
                if (u_output_valid) begin
                    checkOutput("n1_data", u_output_data, utab[i].dout);
                    checkOutput("n1_last", u_output_last, utab[i].last);
                    idx++;
                end
            end
            if (idx != 1) checkOutput("n1_timeout", idx, 1);
        end

        $display("[TB] ramp block");
        applyStimulus(0, N, 1'b1, 1'b0, 1'b1);
        waitDrain();

        $display("[TB] constant block");
        applyStimulus(16'hFFFF, N, 1'b0, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] back-to-back blocks");
        applyStimulus(0, N, 1'b1, 1'b0, 1'b1);
        applyStimulus(256, N, 1'b1, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] backpressure");
        rand_ready = 1'b1;
        applyStimulus(0, N, 1'b1, 1'b1, 1'b0);
        waitDrain();
        rand_ready = 1'b0;

        $display("[TB] reset mid-fill and mid-drain");
        applyStimulus(0, 100, 1'b1, 1'b0, 1'b0);
        doReset();
        applyStimulus(0, N, 1'b1, 1'b0, 1'b0);
        start = out_seen;
        cyc   = 0;
        while (out_seen < start + 50 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        if (out_seen < start + 50) checkOutput("mid_drain_timeout", out_seen - start, 50);
        doReset();
        applyStimulus(0, N, 1'b1, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
